// File: rtl/dram_rmw_adapter_if.sv
// Bundles the upstream request/response and DRAM request/response signals of the RMW adapter.
// slave is the adapter's view; master is the environment's view.
interface dram_rmw_adapter_if #(
    parameter int unsigned DataWidth = 512,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdWidth   = 4
);
    localparam int unsigned StrbWidth = DataWidth / 8;

    logic                 in_valid_i;
    logic                 in_ready_o;
    logic                 in_we_i;
    logic [AddrWidth-1:0] in_addr_i;
    logic [IdWidth-1:0]   in_id_i;
    logic [DataWidth-1:0] in_wdata_i;
    logic [StrbWidth-1:0] in_strb_i;

    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [IdWidth-1:0]   out_id_o;
    logic [DataWidth-1:0] out_rdata_o;

    logic                 dram_req_valid_o;
    logic                 dram_req_ready_i;
    logic                 dram_we_o;
    logic [AddrWidth-1:0] dram_addr_o;
    logic [DataWidth-1:0] dram_wdata_o;
    logic                 dram_rsp_valid_i;
    logic                 dram_rsp_ready_o;
    logic [DataWidth-1:0] dram_rdata_i;

    modport slave (
        input  in_valid_i, in_we_i, in_addr_i, in_id_i, in_wdata_i, in_strb_i,
        output in_ready_o,
        input  out_ready_i,
        output out_valid_o, out_id_o, out_rdata_o,
        input  dram_req_ready_i, dram_rsp_valid_i, dram_rdata_i,
        output dram_req_valid_o, dram_we_o, dram_addr_o, dram_wdata_o, dram_rsp_ready_o
    );

    modport master (
        output in_valid_i, in_we_i, in_addr_i, in_id_i, in_wdata_i, in_strb_i,
        input  in_ready_o,
        output out_ready_i,
        input  out_valid_o, out_id_o, out_rdata_o,
        output dram_req_ready_i, dram_rsp_valid_i, dram_rdata_i,
        input  dram_req_valid_o, dram_we_o, dram_addr_o, dram_wdata_o, dram_rsp_ready_o
    );
endinterface

// File: rtl/dram_rmw_adapter.sv
// Adapts byte-strobed, ID-tagged upstream requests to a strobe-less DRAM port.
// Partial writes become read-modify-write; read responses return in order with their ID.
module dram_rmw_adapter #(
    parameter int unsigned DataWidth = 512,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned MaxReads  = 8
) (
    input logic               clk_i,
    input logic               rst_ni,
    dram_rmw_adapter_if.slave bus_io
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned PtrWidth  = $clog2(MaxReads) + 1;
    localparam int unsigned IdxWidth  = PtrWidth - 1;
    localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(StrbWidth - 1);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StRmwRd   = 2'd1;
    localparam logic [1:0] StRmwWait = 2'd2;
    localparam logic [1:0] StRmwWr   = 2'd3;

    logic [1:0] state_q, state_d;

    // Tag FIFO: one entry per outstanding DRAM read, in issue order.
    logic [MaxReads-1:0][IdWidth-1:0] tag_id_q;
    logic [MaxReads-1:0]              tag_int_q;
    logic [PtrWidth-1:0]              wr_ptr_q, rd_ptr_q;
    logic [IdxWidth-1:0]              wr_idx, rd_idx;
    logic                             fifo_empty, fifo_full;
    logic                             head_int;
    logic                             push, push_int, pop, pop_int;
    logic [IdWidth-1:0]               push_id;

    logic [AddrWidth-1:0] hold_addr_q;
    logic [DataWidth-1:0] hold_wdata_q;
    logic [StrbWidth-1:0] hold_strb_q;
    logic [DataWidth-1:0] merged_q, merged_d;
    logic                 hold_load;

    logic                 in_ready;
    logic                 req_valid, req_we;
    logic [AddrWidth-1:0] req_addr;
    logic [DataWidth-1:0] req_wdata;
    logic                 out_valid, rsp_ready;
    logic                 strb_all, strb_none;

    assign wr_idx     = wr_ptr_q[IdxWidth-1:0];
    assign rd_idx     = rd_ptr_q[IdxWidth-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_idx == rd_idx) && (wr_ptr_q[PtrWidth-1] != rd_ptr_q[PtrWidth-1]);
    assign head_int   = tag_int_q[rd_idx];
    assign strb_all   = &bus_io.in_strb_i;
    assign strb_none  = ~|bus_io.in_strb_i;
    assign push_id    = push_int ? '0 : bus_io.in_id_i;

    // Response path; an internal head only exists while the RMW waits for its read.
    always_comb begin
        out_valid = 1'b0;
        rsp_ready = 1'b0;
        pop       = 1'b0;
        pop_int   = 1'b0;
        if (fifo_empty) begin
            rsp_ready = 1'b1;
        end else if (head_int) begin
            if (bus_io.dram_rsp_valid_i) begin
                rsp_ready = 1'b1;
                pop       = 1'b1;
                pop_int   = 1'b1;
            end
        end else begin
            out_valid = bus_io.dram_rsp_valid_i;
            rsp_ready = bus_io.out_ready_i;
            pop       = out_valid & bus_io.out_ready_i;
        end
        if (!rst_ni) begin
            out_valid = 1'b0;
            rsp_ready = 1'b0;
        end
    end

    always_comb begin
        merged_d = bus_io.dram_rdata_i;
        for (int unsigned b = 0; b < StrbWidth; b++) begin
            if (hold_strb_q[b]) merged_d[8*b +: 8] = hold_wdata_q[8*b +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = bus_io.in_addr_i & AlignMask;
        req_wdata = bus_io.in_wdata_i;
        push      = 1'b0;
        push_int  = 1'b0;
        hold_load = 1'b0;
        case (state_q)
            StIdle: begin
                if (!bus_io.in_we_i) begin
                    req_valid = bus_io.in_valid_i & ~fifo_full;
                    in_ready  = bus_io.dram_req_ready_i & ~fifo_full;
                    push      = bus_io.in_valid_i & in_ready;
                end else if (strb_all) begin
                    req_valid = bus_io.in_valid_i;
                    req_we    = 1'b1;
                    in_ready  = bus_io.dram_req_ready_i;
                end else if (strb_none) begin
                    in_ready = 1'b1;
                end else begin
                    // Partial write needs a FIFO slot for its internal read.
                    in_ready = ~fifo_full;
                    if (bus_io.in_valid_i && in_ready) begin
                        hold_load = 1'b1;
                        state_d   = StRmwRd;
                    end
                end
            end
            StRmwRd: begin
                req_valid = 1'b1;
                req_addr  = hold_addr_q;
                if (bus_io.dram_req_ready_i) begin
                    push     = 1'b1;
                    push_int = 1'b1;
                    state_d  = StRmwWait;
                end
            end
            StRmwWait: begin
                if (pop_int) state_d = StRmwWr;
            end
            StRmwWr: begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_addr  = hold_addr_q;
                req_wdata = merged_q;
                if (bus_io.dram_req_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (!rst_ni) begin
            in_ready  = 1'b0;
            req_valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            tag_id_q     <= '0;
            tag_int_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            hold_strb_q  <= '0;
            merged_q     <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                tag_id_q[wr_idx]  <= push_id;
                tag_int_q[wr_idx] <= push_int;
                wr_ptr_q          <= wr_ptr_q + PtrWidth'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            if (hold_load) begin
                hold_addr_q  <= bus_io.in_addr_i & AlignMask;
                hold_wdata_q <= bus_io.in_wdata_i;
                hold_strb_q  <= bus_io.in_strb_i;
            end
            if (pop_int) merged_q <= merged_d;
        end
    end

    // A DRAM beat with no outstanding read is a protocol error; it is dropped.
    always @(posedge clk_i) begin
        if (rst_ni && bus_io.dram_rsp_valid_i) assert (!fifo_empty);
    end

    assign bus_io.in_ready_o       = in_ready;
    assign bus_io.out_valid_o      = out_valid;
    assign bus_io.out_id_o         = tag_id_q[rd_idx];
    assign bus_io.out_rdata_o      = bus_io.dram_rdata_i;
    assign bus_io.dram_req_valid_o = req_valid;
    assign bus_io.dram_we_o        = req_we;
    assign bus_io.dram_addr_o      = req_addr;
    assign bus_io.dram_wdata_o     = req_wdata;
    assign bus_io.dram_rsp_ready_o = rsp_ready;
endmodule

// File: tb/tb_dram_rmw_adapter.sv
// Bench for dram_rmw_adapter: a DRAM model plus a byte-level reference memory and read queue,
// driven by directed scenarios and randomized traffic.
module tb_dram_rmw_adapter;
    localparam int unsigned DW = 512;
    localparam int unsigned AW = 64;
    localparam int unsigned IW = 4;
    localparam int unsigned SW = DW / 8;

    typedef logic [DW-1:0] beat_t;
    typedef logic [AW-1:0] addr_t;
    typedef struct {logic [IW-1:0] id; beat_t data; int cyc;} rsp_t;
    typedef struct {addr_t addr; beat_t data; int cyc;} wr_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dram_rmw_adapter_if #(.DataWidth(DW), .AddrWidth(AW), .IdWidth(IW)) bus ();

    dram_rmw_adapter #(.DataWidth(DW), .AddrWidth(AW), .IdWidth(IW), .MaxReads(8)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_io(bus)
    );

    beat_t ref_mem [addr_t];
    beat_t dram_mem[addr_t];
    rsp_t  exp_q[$];
    rsp_t  got_q[$];
    wr_t   wr_log[$];
    beat_t rd_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_dram_rd = 0;
    int acc_cyc = 0;
    int rmw_viol = 0;
    int misalign = 0;
    bit rmw_busy = 0;

    bit              up_active = 0;
    logic            up_we;
    addr_t           up_addr;
    logic [IW-1:0]   up_id;
    beat_t           up_wdata;
    logic [SW-1:0]   up_strb;
    int req_prob = 100;
    int rsp_prob = 100;
    int out_mode = 0;
    bit rsp_hold = 0;

    function automatic beat_t init_beat(addr_t a);
        beat_t b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = a[31:0] ^ (32'h1357_9BDF * 32'(i + 1));
        return b;
    endfunction

    function automatic beat_t ref_rd(addr_t a);
        return ref_mem.exists(a) ? ref_mem[a] : init_beat(a);
    endfunction

    function automatic beat_t dram_rd(addr_t a);
        return dram_mem.exists(a) ? dram_mem[a] : init_beat(a);
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // One clock: drive at the falling edge, settle, update models with what fires at the rise.
    task automatic step();
        addr_t a;
        beat_t nb;
        bus.in_valid_i       = up_active;
        bus.in_we_i          = up_we;
        bus.in_addr_i        = up_addr;
        bus.in_id_i          = up_id;
        bus.in_wdata_i       = up_wdata;
        bus.in_strb_i        = up_strb;
        bus.dram_req_ready_i = ($urandom_range(99) < req_prob);
        bus.dram_rsp_valid_i = (rd_q.size() != 0) && !rsp_hold && ($urandom_range(99) < rsp_prob);
        bus.dram_rdata_i     = (rd_q.size() != 0) ? rd_q[0] : rand_beat();
        bus.out_ready_i      = (out_mode == 0) ? 1'b1 : (out_mode == 1) ? cyc[0] : 1'($urandom_range(1));
        #1;
        if (!rst_n) begin
            rd_q.delete();
            rmw_busy = 0;
        end else begin
            if (bus.in_ready_o && rmw_busy) rmw_viol++;
            if (bus.out_valid_o && bus.out_ready_i)
                got_q.push_back('{id: bus.out_id_o, data: bus.out_rdata_o, cyc: cyc});
            if (bus.dram_rsp_valid_i && bus.dram_rsp_ready_o) void'(rd_q.pop_front());
            if (bus.dram_req_valid_o && bus.dram_req_ready_i) begin
                if (bus.dram_addr_o[5:0] != 6'd0) misalign++;
                if (bus.dram_we_o) begin
                    dram_mem[bus.dram_addr_o] = bus.dram_wdata_o;
                    wr_log.push_back('{addr: bus.dram_addr_o, data: bus.dram_wdata_o, cyc: cyc});
                    rmw_busy = 0;
                end else begin
                    rd_q.push_back(dram_rd(bus.dram_addr_o));
                    n_dram_rd++;
                end
            end
            if (up_active && bus.in_ready_o) begin
                a = up_addr & ~addr_t'(SW - 1);
                if (!up_we) begin
                    exp_q.push_back('{id: up_id, data: ref_rd(a), cyc: cyc});
                end else if (up_strb != '0) begin
                    nb = ref_rd(a);
                    for (int b = 0; b < SW; b++) if (up_strb[b]) nb[8*b +: 8] = up_wdata[8*b +: 8];
                    ref_mem[a] = nb;
                    if (up_strb != '1) rmw_busy = 1;
                end
                up_active = 0;
                acc_cyc = cyc;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic issue(input logic we, input addr_t addr, input logic [IW-1:0] id,
                         input beat_t wd, input logic [SW-1:0] strb);
        int n = 0;
        up_we = we; up_addr = addr; up_id = id; up_wdata = wd; up_strb = strb;
        up_active = 1;
        while (up_active && n < 300) begin step(); n++; end
        n_checks++;
        if (up_active) begin
            n_fail++;
            $display("FAIL issue_timeout: addr=%h still not accepted after %0d cycles", addr, n);
            up_active = 0;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (!(rd_q.size() == 0 && !up_active && !rmw_busy && got_q.size() >= exp_q.size())
               && n < budget) begin
            step(); n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d of %0d responses, %0d DRAM beats pending",
                     got_q.size(), exp_q.size(), rd_q.size());
        end
        step(); step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid_i = 1'b1; bus.in_we_i = 1'b1; bus.in_strb_i = '0;
        bus.in_addr_i = '0; bus.in_id_i = '0; bus.in_wdata_i = '0;
        bus.dram_req_ready_i = 1'b1; bus.dram_rsp_valid_i = 1'b1; bus.dram_rdata_i = '0;
        bus.out_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks += 4;
        if (bus.in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready_o); end
        if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid_o); end
        if (bus.dram_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", bus.dram_req_valid_o); end
        if (bus.dram_rsp_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_ready: got %b want 0", bus.dram_rsp_ready_o); end
        bus.dram_rsp_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL idle_zero_strobe_ready: got %b want 1", bus.in_ready_o); end
        bus.in_valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        addr_t a = 64'h8000_0040;
        ref_mem[a] = {64{8'hAA}};
        dram_mem[a] = {64{8'hAA}};
        issue(1'b0, a, 4'd3, '0, '0);
        drain(50);
        n_checks += 3;
        if (got_q.size() != 1) begin
            n_fail++; $display("FAIL read_count: got %0d want 1", got_q.size());
        end else begin
            if (got_q[0].id !== 4'd3) begin n_fail++; $display("FAIL read_id: got %0d want 3", got_q[0].id); end
            if (got_q[0].data !== {64{8'hAA}}) begin n_fail++; $display("FAIL read_data: got %h want all AA", got_q[0].data); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_full_write();
        addr_t a = 64'h8000_0000;
        beat_t d = rand_beat();
        int w0 = wr_log.size();
        issue(1'b1, a, 4'd0, d, '1);
        repeat (3) step();
        n_checks += 3;
        if (wr_log.size() != w0 + 1) begin
            n_fail++; $display("FAIL full_write_count: got %0d want 1", wr_log.size() - w0);
        end else begin
            if (wr_log[w0].cyc != acc_cyc) begin n_fail++; $display("FAIL full_write_same_cycle: write at %0d accept at %0d", wr_log[w0].cyc, acc_cyc); end
            if (wr_log[w0].addr !== a || wr_log[w0].data !== d) begin
                n_fail++; $display("FAIL full_write_data: got %h @%h want %h @%h", wr_log[w0].data, wr_log[w0].addr, d, a);
            end
        end
        n_checks++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL full_write_no_rsp: got %0d responses want 0", got_q.size()); end
        issue(1'b0, a, 4'd5, '0, '0);
        drain(50);
        n_checks++;
        if (got_q.size() != 1 || got_q[0].data !== d || got_q[0].id !== 4'd5) begin
            n_fail++; $display("FAIL full_write_readback: got %0d rsp data %h want id 5 data %h", got_q.size(),
                               (got_q.size() != 0) ? got_q[0].data : '0, d);
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_partial_write();
        addr_t a = 64'h8000_0080;
        beat_t d = rand_beat();
        beat_t want = {{63{8'hFF}}, 8'h55};
        int r0 = n_dram_rd;
        int w0 = wr_log.size();
        int v0 = rmw_viol;
        ref_mem[a] = {64{8'hFF}};
        dram_mem[a] = {64{8'hFF}};
        d[7:0] = 8'h55;
        issue(1'b1, a, 4'd1, d, 64'h1);
        // Zero-strobe write held behind the RMW shows when upstream is released.
        issue(1'b1, a, 4'd2, rand_beat(), '0);
        repeat (2) step();
        n_checks += 4;
        if (n_dram_rd != r0 + 1) begin n_fail++; $display("FAIL rmw_read_count: got %0d want 1", n_dram_rd - r0); end
        if (rmw_viol != v0) begin n_fail++; $display("FAIL rmw_in_ready: in_ready high %0d cycles during RMW want 0", rmw_viol - v0); end
        if (got_q.size() != 0) begin n_fail++; $display("FAIL rmw_no_rsp: got %0d responses want 0", got_q.size()); end
        if (wr_log.size() != w0 + 1) begin
            n_fail++; $display("FAIL rmw_write_count: got %0d want 1", wr_log.size() - w0);
        end else begin
            n_checks += 2;
            if (wr_log[w0].data !== want || wr_log[w0].addr !== a) begin
                n_fail++; $display("FAIL rmw_merge: got %h @%h want %h @%h", wr_log[w0].data, wr_log[w0].addr, want, a);
            end
            if (acc_cyc <= wr_log[w0].cyc) begin
                n_fail++; $display("FAIL rmw_block: next request accepted at %0d, write at %0d", acc_cyc, wr_log[w0].cyc);
            end
        end
    endtask

    task automatic test_fifo_full();
        rsp_hold = 1;
        for (int i = 0; i < 8; i++) issue(1'b0, 64'h8000_2000 + 64'(64 * i), 4'(i), '0, '0);
        up_we = 1'b0; up_addr = 64'h8000_2400; up_id = 4'd8; up_active = 1;
        repeat (6) step();
        n_checks++;
        if (!up_active) begin n_fail++; $display("FAIL fifo_full_block: ninth read accepted at %0d want blocked", acc_cyc); end
        rsp_hold = 0;
        out_mode = 1;
        drain(200);
        out_mode = 0;
        n_checks++;
        if (got_q.size() != 9) begin n_fail++; $display("FAIL fifo_full_count: got %0d want 9", got_q.size()); end
        for (int i = 0; i < 9 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i].id !== 4'(i) || got_q[i].data !== exp_q[i].data) begin
                n_fail++; $display("FAIL fifo_order[%0d]: got id %0d data %h want id %0d data %h",
                                   i, got_q[i].id, got_q[i].data, i, exp_q[i].data);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reads_then_partial();
        addr_t a = 64'h8000_0100;
        logic [SW-1:0] s = {$urandom, $urandom};
        int w0 = wr_log.size();
        if (&s || s == '0) s = 64'h0000_0000_0000_FF02;
        rsp_hold = 1;
        issue(1'b0, a, 4'd9, '0, '0);
        issue(1'b0, a + 64'h40, 4'd10, '0, '0);
        issue(1'b1, a, 4'd0, rand_beat(), s);
        repeat (4) step();
        rsp_hold = 0;
        drain(100);
        n_checks += 2;
        if (got_q.size() != 2) begin n_fail++; $display("FAIL mixed_rsp_count: got %0d want 2", got_q.size()); end
        if (wr_log.size() != w0 + 1) begin
            n_fail++; $display("FAIL mixed_write_count: got %0d want 1", wr_log.size() - w0);
        end else begin
            n_checks++;
            if (wr_log[w0].data !== ref_rd(a)) begin
                n_fail++; $display("FAIL mixed_merge: got %h want %h", wr_log[w0].data, ref_rd(a));
            end
            for (int i = 0; i < 2 && i < got_q.size(); i++) begin
                n_checks++;
                if (got_q[i].id !== exp_q[i].id || got_q[i].data !== exp_q[i].data ||
                    got_q[i].cyc >= wr_log[w0].cyc) begin
                    n_fail++; $display("FAIL mixed_rsp[%0d]: got id %0d at %0d want id %0d before write at %0d",
                                       i, got_q[i].id, got_q[i].cyc, exp_q[i].id, wr_log[w0].cyc);
                end
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_rmw();
        addr_t a = 64'h8000_00C0;
        beat_t old = ref_rd(a);
        int r0 = n_dram_rd;
        int w0;
        int n = 0;
        rsp_hold = 1;
        issue(1'b1, a, 4'd0, rand_beat(), 64'h0000_00F0_0000_000F);
        while (n_dram_rd == r0 && n < 50) begin step(); n++; end
        w0 = wr_log.size();
        rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (bus.in_ready_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_in_ready: got %b want 0", bus.in_ready_o); end
        if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out_valid: got %b want 0", bus.out_valid_o); end
        if (bus.dram_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_req_valid: got %b want 0", bus.dram_req_valid_o); end
        if (bus.dram_rsp_ready_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_rsp_ready: got %b want 0", bus.dram_rsp_ready_o); end
        step();
        ref_mem[a] = old;
        rsp_hold = 0;
        rst_n = 1'b1;
        repeat (5) step();
        n_checks++;
        if (wr_log.size() != w0) begin n_fail++; $display("FAIL mid_reset_no_write: got %0d writes want 0", wr_log.size() - w0); end
        issue(1'b0, a, 4'd2, '0, '0);
        drain(50);
        n_checks++;
        if (got_q.size() != 1 || got_q[0].id !== 4'd2 || got_q[0].data !== old) begin
            n_fail++; $display("FAIL mid_reset_readback: got %0d rsp data %h want id 2 data %h", got_q.size(),
                               (got_q.size() != 0) ? got_q[0].data : '0, old);
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int op;
        logic [SW-1:0] s;
        addr_t base = 64'h8000_1000;
        req_prob = 70; rsp_prob = 60; out_mode = 2;
        for (int t = 0; t < 400; t++) begin
            op = $urandom_range(9);
            s = {$urandom, $urandom};
            if (&s || s == '0) s = 64'h0000_0000_0000_FF02;
            if (op >= 4 && op <= 5) s = '1;
            if (op == 9) s = '0;
            issue(op >= 4, base + 64'(64 * $urandom_range(7)) + 64'($urandom_range(63)),
                  4'($urandom_range(15)), rand_beat(), s);
            if ($urandom_range(3) == 0) step();
        end
        drain(3000);
        req_prob = 100; rsp_prob = 100; out_mode = 0;
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i].id !== exp_q[i].id || got_q[i].data !== exp_q[i].data) begin
                n_fail++; $display("FAIL rand_rsp[%0d]: got id %0d data %h want id %0d data %h",
                                   i, got_q[i].id, got_q[i].data, exp_q[i].id, exp_q[i].data);
            end
        end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (dram_rd(base + 64'(64 * k)) !== ref_rd(base + 64'(64 * k))) begin
                n_fail++; $display("FAIL rand_mem[%0d]: got %h want %h", k, dram_rd(base + 64'(64 * k)),
                                   ref_rd(base + 64'(64 * k)));
            end
        end
        n_checks += 2;
        if (rmw_viol != 0) begin n_fail++; $display("FAIL rand_rmw_block: in_ready high %0d cycles during RMW want 0", rmw_viol); end
        if (misalign != 0) begin n_fail++; $display("FAIL rand_align: %0d unaligned DRAM addresses want 0", misalign); end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        up_we = 1'b0; up_addr = '0; up_id = '0; up_wdata = '0; up_strb = '0;
        @(negedge clk);
        test_reset();
        test_read();
        test_full_write();
        test_partial_write();
        test_fifo_full();
        test_reads_then_partial();
        test_reset_mid_rmw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
